wconv_fifo: RTL
===============

WCONV_FIFO -- requirements
Module: wconv_fifo

Interface
REQ-001 Parameter DEPTH_LOG2, default 4: FIFO depth is 2**DEPTH_LOG2 words of 256 bits.
REQ-002 Parameter PREFILL, default 4: occupancy at which output starts; legal range 1..2**DEPTH_LOG2.
REQ-003 aclk  input  1  clock; all logic on rising edge.
REQ-004 aresetn  input  1  synchronous, active-low reset.
REQ-005 s_axis_tvalid  input  1  input word valid; no tready, source never stalls.
REQ-006 s_axis_tdata  input  256  16 x 16-bit samples, sample 0 in bits [15:0].
REQ-007 m_axis_tvalid  output  1  output word valid, toward DAC.
REQ-008 m_axis_tdata  output  256  output word, same packing as input.
REQ-009 m_axis_tready  input  1  DAC-side consume strobe.
REQ-010 clr  input  1  clears sticky flags (and counters when enabled), one-cycle pulse.
REQ-011 ovf  output  1  sticky overflow flag.
REQ-012 udf  output  1  sticky underflow flag.
REQ-013 occupancy  output  DEPTH_LOG2+1  current word count.

Function
REQ-014 Write: word stored when s_axis_tvalid=1 and (not full, or a read occurs in the same cycle).
REQ-015 Overflow: s_axis_tvalid=1, full, no read -> word dropped, ovf set next cycle, pointers unchanged.
REQ-016 Read: word popped when m_axis_tvalid=1 and m_axis_tready=1.
REQ-017 First-word-fall-through: m_axis_tdata shows word at read pointer; a word written on edge N is visible from cycle N+1.
REQ-018 State machine FILL/RUN; reset state FILL.
REQ-019 FILL: m_axis_tvalid=0; FILL->RUN on the edge where registered occupancy >= PREFILL.
REQ-020 RUN: m_axis_tvalid = not empty.
REQ-021 Underflow: RUN, m_axis_tready=1, empty -> udf set, state->FILL next cycle.
REQ-022 Simultaneous read and write: occupancy unchanged; legal at full and at empty (empty: write only, no read).
REQ-023 Pointers are DEPTH_LOG2 bits and wrap modulo 2**DEPTH_LOG2; full/empty derived from occupancy.
REQ-024 clr has priority over a same-cycle set of ovf/udf: flags read 0 the cycle after clr.

Reset
REQ-025 aresetn=0 -> state FILL, pointers 0, occupancy 0, ovf 0, udf 0, m_axis_tvalid 0, counters 0.
REQ-026 Memory contents are not reset; m_axis_tdata is don't-care while m_axis_tvalid=0.
REQ-027 Reset mid-operation discards all stored words; first post-reset write is read first.

Configuration
REQ-028 Macro WCONV_FIFO_STATS_EN defined: adds outputs ovf_cnt and udf_cnt, 16 bits each, counting events, saturating at 0xFFFF, cleared by clr and reset.
REQ-029 Macro undefined: those ports and counters are absent; all other behaviour identical.

Structure
REQ-030 Package wconv_pkg holds SAMPLE_W=16, SAMPLES_OUT=16, DATA_W=256, typedef for the 256-bit word and the FILL/RUN state enum.
REQ-031 Storage is sub-module wconv_fifo_mem: dual-port register array, one synchronous write port, one asynchronous read port.
REQ-032 Control (pointers, occupancy, FSM, flags) stays in wconv_fifo.

Verification
REQ-033 Input valid pattern 1,1,1,0 repeating; tready held 0 -> m_axis_tvalid rises the cycle after occupancy reaches 4; ovf set after 16 accepted words.
REQ-034 Input 3-of-4 pattern, tready 3-of-4 offset by 2 cycles, 1000 cycles -> all words out in order (counting-sample data), ovf=0, udf=0.
REQ-035 Prefill 4, then tready=1 constantly with input 3-of-4 -> udf=1 and state returns to FILL; output resumes after 4 more writes.
REQ-036 Full FIFO (16 words), simultaneous write and read -> occupancy stays 16, ovf=0, next word out is word 1.
REQ-037 clr asserted in the same cycle as an overflow -> ovf=0 the next cycle; with WCONV_FIFO_STATS_EN, ovf_cnt=0.
REQ-038 aresetn pulsed low with 7 words stored -> occupancy 0, m_axis_tvalid 0, and the first post-reset word 0xA5..A5 is read first after prefill.

Source files
------------

// File: rtl/wconv_pkg.sv
// -----------------------------------------------------------------------------
// wconv_pkg
// Shared types and constants for the DAC-side word FIFO (wconv_fifo).
//   SAMPLE_W    : bits per sample
//   SAMPLES_OUT : samples packed per word (sample 0 in the low bits)
//   DATA_W      : word width
//   word_t      : one packed 256-bit word
//   state_t     : output-side FSM states (FILL waits for prefill, RUN streams)
// -----------------------------------------------------------------------------
package wconv_pkg;

    localparam int SAMPLE_W    = 16;
    localparam int SAMPLES_OUT = 16;
    localparam int DATA_W      = SAMPLE_W * SAMPLES_OUT;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Event counter step that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/wconv_fifo_mem.sv
// -----------------------------------------------------------------------------
// wconv_fifo_mem
// Register-array storage for wconv_fifo: one synchronous write port and one
// asynchronous (combinational) read port, so the word at the read address is
// visible in the same cycle it is addressed.
//   aclk    : clock, write on rising edge
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : word to store
//   rd_addr : read address
//   rd_data : word currently stored at rd_addr
// -----------------------------------------------------------------------------
module wconv_fifo_mem
    import wconv_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              aclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  word_t             wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output word_t             rd_data
);

    word_t mem_q [2**ADDR_W];

    // NOTE: the array has no reset; stale contents are never exposed because
    // the controller only flags data valid for words written since reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/wconv_fifo.sv
// -----------------------------------------------------------------------------
// wconv_fifo
// Word FIFO feeding a DAC. The source never stalls (no tready); words arriving
// while full are dropped and flagged. Output stays idle (FILL) until the FIFO
// holds PREFILL words, then streams (RUN) first-word-fall-through. Running dry
// while the DAC asks for data flags underflow and returns to FILL.
//
// Optional build macro WCONV_FIFO_STATS_EN adds saturating 16-bit event
// counters ovf_cnt / udf_cnt.
//
// Ports:
//   aclk, aresetn   : clock; synchronous active-low reset
//   s_axis_tvalid   : input word valid
//   s_axis_tdata    : input word (16 x 16-bit samples)
//   m_axis_tvalid   : output word valid
//   m_axis_tdata    : output word (head of FIFO)
//   m_axis_tready   : DAC consume strobe
//   clr             : clears sticky flags (and counters when present)
//   ovf, udf        : sticky overflow / underflow flags
//   occupancy       : current word count
//   ovf_cnt, udf_cnt: event counters (WCONV_FIFO_STATS_EN only)
// -----------------------------------------------------------------------------
module wconv_fifo
    import wconv_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_axis_tvalid,
    input  word_t                 s_axis_tdata,
    output logic                  m_axis_tvalid,
    output word_t                 m_axis_tdata,
    input  logic                  m_axis_tready,
    input  logic                  clr,
    output logic                  ovf,
    output logic                  udf,
    output logic [DEPTH_LOG2:0]   occupancy
`ifdef WCONV_FIFO_STATS_EN
    ,
    output logic [15:0]           ovf_cnt,
    output logic [15:0]           udf_cnt
`endif
);

    localparam int                OCC_W     = DEPTH_LOG2 + 1;
    localparam int                DEPTH     = 2**DEPTH_LOG2;
    localparam logic [OCC_W-1:0]  DEPTH_C   = DEPTH[OCC_W-1:0];
    localparam logic [OCC_W-1:0]  PREFILL_C = PREFILL[OCC_W-1:0];

    state_t                 state_q,  state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       occ_q,    occ_d;
    logic                   ovf_q,    ovf_d;
    logic                   udf_q,    udf_d;

    logic full, empty, rd_en, wr_en, ovf_evt, udf_evt;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;

        full  = (occ_q == DEPTH_C);
        empty = (occ_q == '0);

        m_axis_tvalid = (state_q == ST_RUN) && !empty;
        rd_en         = m_axis_tvalid && m_axis_tready;
        // A same-cycle read frees a slot, so a full FIFO still accepts.
        wr_en         = s_axis_tvalid && (!full || rd_en);
        ovf_evt       = s_axis_tvalid && full && !rd_en;
        udf_evt       = (state_q == ST_RUN) && m_axis_tready && empty;

        unique case (state_q)
            ST_FILL: if (occ_q >= PREFILL_C) state_d = ST_RUN;
            ST_RUN:  if (udf_evt)            state_d = ST_FILL;
            default:                         state_d = ST_FILL;
        endcase

        if (wr_en) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);

        unique case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // clr wins over a same-cycle event.
        ovf_d = !clr && (ovf_q || ovf_evt);
        udf_d = !clr && (udf_q || udf_evt);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= ST_FILL;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    assign ovf       = ovf_q;
    assign udf       = udf_q;
    assign occupancy = occ_q;

`ifdef WCONV_FIFO_STATS_EN
    logic [15:0] ovf_cnt_q, ovf_cnt_d;
    logic [15:0] udf_cnt_q, udf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        udf_cnt_d = udf_cnt_q;
        if (clr) begin
            ovf_cnt_d = '0;
            udf_cnt_d = '0;
        end else begin
            if (ovf_evt) ovf_cnt_d = sat_inc16(ovf_cnt_q);
            if (udf_evt) udf_cnt_d = sat_inc16(udf_cnt_q);
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`endif

    wconv_fifo_mem #(
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .aclk    (aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (s_axis_tdata),
        .rd_addr (rd_ptr_q),
        .rd_data (m_axis_tdata)
    );

endmodule
